// File: rtl/arbitro_escritura_reg_4b.sv
// Round-robin write-port arbiter/sequencer for a W-bit parallel register.
// Define ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module arbitro_escritura_reg_4b #(
    parameter int N_REQ = 4,
    parameter int W     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*W-1:0]         req_d,
    output logic [N_REQ-1:0]           gnt,
    output logic [N_REQ-1:0]           ack,
    output logic                       reg_en,
    output logic [W-1:0]               reg_d,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic                       busy
);

    localparam int PW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_WRITE,
        S_ACK
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     win_q, win_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic              reg_en_q, reg_en_d;
    logic [W-1:0]      reg_d_q, reg_d_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic              busy_q, busy_d;
`ifndef ARB_FIXED_PRIO_EN
    logic [PW-1:0]     ptr_q, ptr_d;
`endif

    logic              found;
    logic [PW-1:0]     sel;
    int                start;
    int                idx;

    function automatic logic [N_REQ-1:0] onehot(input logic [PW-1:0] i);
        return N_REQ'(1) << i;
    endfunction

`ifndef ARB_FIXED_PRIO_EN
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] i);
        int n;
        n = int'(i) + 1;
        if (n >= N_REQ) n = 0;
        return PW'(n);
    endfunction
`endif

    // Winner search: first set request at or after the start index, wrapping at N_REQ-1.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
`ifdef ARB_FIXED_PRIO_EN
        start = 0;
`else
        start = int'(ptr_q);
`endif
        for (int k = 0; k < N_REQ; k++) begin
            idx = start + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = PW'(idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        gnt_d    = gnt_q;
        ack_d    = '0;
        reg_en_d = 1'b0;
        reg_d_d  = reg_d_q;
        owner_d  = owner_q;
`ifndef ARB_FIXED_PRIO_EN
        ptr_d    = ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    win_d   = sel;
                    gnt_d   = onehot(sel);
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                // Data is captured straight into the output register; it is then frozen.
                if (req[win_q]) begin
                    reg_d_d  = req_d[int'(win_q)*W +: W];
                    reg_en_d = 1'b1;
                    state_d  = S_WRITE;
                end else begin
                    gnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                ack_d   = gnt_q;
                state_d = S_ACK;
            end
            S_ACK: begin
                owner_d = win_q;
`ifndef ARB_FIXED_PRIO_EN
                ptr_d   = next_ptr(win_q);
`endif
                gnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            win_q    <= '0;
            gnt_q    <= '0;
            ack_q    <= '0;
            reg_en_q <= 1'b0;
            reg_d_q  <= '0;
            owner_q  <= '0;
            busy_q   <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            ptr_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            reg_en_q <= reg_en_d;
            reg_d_q  <= reg_d_d;
            owner_q  <= owner_d;
            busy_q   <= busy_d;
`ifndef ARB_FIXED_PRIO_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

    assign gnt    = gnt_q;
    assign ack    = ack_q;
    assign reg_en = reg_en_q;
    assign reg_d  = reg_d_q;
    assign owner  = owner_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_arbitro_escritura_reg_4b.sv
// Directed bench for arbitro_escritura_reg_4b with a behavioural 4-bit register on its write port.
module tb_arbitro_escritura_reg_4b;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] req_d;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic        reg_en;
    logic [3:0]  reg_d;
    logic [1:0]  owner;
    logic        busy;
    logic [3:0]  reg_q;

    int n_assert = 0;
    int n_fail   = 0;

    arbitro_escritura_reg_4b #(.N_REQ(4), .W(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .req_d  (req_d),
        .gnt    (gnt),
        .ack    (ack),
        .reg_en (reg_en),
        .reg_d  (reg_d),
        .owner  (owner),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst)        reg_q <= 4'h0;
        else if (reg_en) reg_q <= reg_d;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] eg, input logic [3:0] ea,
                           input logic een, input logic [1:0] eo, input logic eb);
        chk({tag, ".gnt"},    32'(gnt),    32'(eg));
        chk({tag, ".ack"},    32'(ack),    32'(ea));
        chk({tag, ".reg_en"}, 32'(reg_en), 32'(een));
        chk({tag, ".owner"},  32'(owner),  32'(eo));
        chk({tag, ".busy"},   32'(busy),   32'(eb));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        rst   = 1'b0;
        req   = 4'b1111;
        req_d = 16'h0000;

        // Reset held with all requests pending
        step();
        step();
        chk_out("rst", 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
        chk("rst.reg_d", 32'(reg_d), 32'h0);
        rst = 1'b1;
        step();
        chk_out("rst_rel", 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b1);
        req = 4'b0000;
        step();
        chk_out("rst_abort", 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);

        // Single write from requester 2
        req   = 4'b0100;
        req_d = 16'h0B00;
        step();
        chk_out("sw.e0", 4'b0100, 4'b0000, 1'b0, 2'd0, 1'b1);
        step();
        chk_out("sw.e1", 4'b0100, 4'b0000, 1'b1, 2'd0, 1'b1);
        chk("sw.reg_d", 32'(reg_d), 32'hB);
        step();
        chk_out("sw.e2", 4'b0100, 4'b0100, 1'b0, 2'd0, 1'b1);
        chk("sw.reg_q", 32'(reg_q), 32'hB);
        req = 4'b0000;
        step();
        chk_out("sw.e3", 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0);
        chk("sw.reg_q3", 32'(reg_q), 32'hB);

        // Late drop and data change during WRITE (requester 3)
        req   = 4'b1000;
        req_d = 16'h3000;
        step();
        chk_out("ld.e0", 4'b1000, 4'b0000, 1'b0, 2'd2, 1'b1);
        step();
        chk_out("ld.e1", 4'b1000, 4'b0000, 1'b1, 2'd2, 1'b1);
        chk("ld.reg_d", 32'(reg_d), 32'h3);
        req_d = 16'hC000;
        req   = 4'b0000;
        step();
        chk_out("ld.e2", 4'b1000, 4'b1000, 1'b0, 2'd2, 1'b1);
        chk("ld.reg_d_hold", 32'(reg_d), 32'h3);
        chk("ld.reg_q", 32'(reg_q), 32'h3);
        step();
        chk_out("ld.e3", 4'b0000, 4'b0000, 1'b0, 2'd3, 1'b0);

        // Round-robin fairness with all requests held; requester i drives i+1
        req   = 4'b1111;
        req_d = 16'h4321;
        for (int g = 0; g < 5; g++) begin
`ifdef ARB_FIXED_PRIO_EN
            w = 0;
`else
            w = g % 4;
`endif
            step();
            chk("rr.gnt", 32'(gnt), 32'(1) << w);
            step();
            chk("rr.reg_en", 32'(reg_en), 32'h1);
            chk("rr.reg_d", 32'(reg_d), 32'(w + 1));
            step();
            chk("rr.ack", 32'(ack), 32'(1) << w);
            step();
            if (g == 4) req = 4'b0000;
            chk("rr.owner", 32'(owner), 32'(w));
            chk("rr.busy", 32'(busy), 32'h0);
        end

        // Abort in GRANT: requester 1 pulses req for one cycle
        req = 4'b0010;
        step();
        chk_out("ab.e0", 4'b0010, 4'b0000, 1'b0, 2'd0, 1'b1);
        req = 4'b0000;
        step();
        chk_out("ab.e1", 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
        step();
        chk_out("ab.e2", 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);

        // Pointer unchanged by the abort; then reset cuts the write
        req = 4'b1111;
        step();
`ifdef ARB_FIXED_PRIO_EN
        chk("ptr.gnt", 32'(gnt), 32'b0001);
`else
        chk("ptr.gnt", 32'(gnt), 32'b0010);
`endif
        step();
        chk("mr.reg_en_pre", 32'(reg_en), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk_out("mr.async", 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
        chk("mr.reg_d", 32'(reg_d), 32'h0);
        step();
        chk_out("mr.hold", 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
        req = 4'b1000;
        rst = 1'b1;
        step();
        chk_out("mr.e0", 4'b1000, 4'b0000, 1'b0, 2'd0, 1'b1);
        step();
        chk_out("mr.e1", 4'b1000, 4'b0000, 1'b1, 2'd0, 1'b1);
        chk("mr.reg_d4", 32'(reg_d), 32'h4);
        step();
        chk_out("mr.e2", 4'b1000, 4'b1000, 1'b0, 2'd0, 1'b1);
        req = 4'b0000;
        step();
        chk_out("mr.e3", 4'b0000, 4'b0000, 1'b0, 2'd3, 1'b0);
        chk("mr.reg_q", 32'(reg_q), 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
